// File: rtl/axis_result_tx.sv
// Row FIFO plus 2:1 serializer: buffers 128-bit PPU result rows and emits each as two
// 64-bit AXI-Stream beats (low half first), with TLAST on the final beat of a tile.
module axis_result_tx #(
    parameter int DATA_W     = 64,
    parameter int ROW_W      = 128,
    parameter int FIFO_DEPTH = 4,
    parameter int M_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [M_W-1:0]    i_cfg_m_dim,
    input  logic              i_row_valid,
    output logic              o_row_ready,
    input  logic [ROW_W-1:0]  i_row_data,
    output logic [DATA_W-1:0] axis_out_tdata,
    output logic              axis_out_tvalid,
    input  logic              axis_out_tready,
    output logic              axis_out_tlast,
    output logic              o_busy,
    output logic              o_done
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t             state;
    logic [ROW_W-1:0]   mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW-1:0]      rd_next;
    logic [CW-1:0]      count;
    logic [M_W-1:0]     m_dim;
    logic [M_W-1:0]     rows_in;
    logic [M_W-1:0]     rows_out;
    logic [M_W-1:0]     last_row;
    logic               half;
    logic               fifo_full;
    logic               push;
    logic               fire;
    logic               pop;
    logic [ROW_W-1:0]   head;
    logic [ROW_W-1:0]   head_next;

    // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
    assign fifo_full   = (count == CW'(FIFO_DEPTH));
    assign o_row_ready = (state == STREAM) && !fifo_full && (rows_in < m_dim);
    assign push        = o_row_ready && i_row_valid;
    assign fire        = axis_out_tvalid && axis_out_tready;
    assign pop         = fire && half;
    assign last_row    = (m_dim != '0) ? (m_dim - M_W'(1)) : '0;
    assign rd_next     = rd_ptr + AW'(1);
    assign head        = mem[rd_ptr];
    assign head_next   = mem[rd_next];
    assign o_busy      = (state == STREAM);
    assign o_done      = (state == DONE);

    // Row storage carries no reset; only pointers and counts define its contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= i_row_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            axis_out_tvalid <= 1'b0;
            axis_out_tlast  <= 1'b0;
            axis_out_tdata  <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            m_dim           <= '0;
            rows_in         <= '0;
            rows_out        <= '0;
            half            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        m_dim           <= i_cfg_m_dim;
                        rows_in         <= '0;
                        rows_out        <= '0;
                        half            <= 1'b0;
                        wr_ptr          <= '0;
                        rd_ptr          <= '0;
                        count           <= '0;
                        axis_out_tvalid <= 1'b0;
                        axis_out_tlast  <= 1'b0;
                        state           <= (i_cfg_m_dim != '0) ? STREAM : DONE;
                    end
                end

                STREAM: begin
                    if (push) begin
                        wr_ptr  <= wr_ptr + AW'(1);
                        rows_in <= rows_in + M_W'(1);
                    end
                    if (pop) begin
                        rd_ptr   <= rd_next;
                        rows_out <= rows_out + M_W'(1);
                    end
                    count <= count + CW'(push) - CW'(pop);

                    // The output register always holds a beat of the FIFO head while valid.
                    if (!axis_out_tvalid) begin
                        if (count != '0) begin
                            axis_out_tdata  <= head[DATA_W-1:0];
                            axis_out_tlast  <= 1'b0;
                            axis_out_tvalid <= 1'b1;
                            half            <= 1'b0;
                        end
                    end else if (fire) begin
                        if (!half) begin
                            axis_out_tdata <= head[ROW_W-1:DATA_W];
                            axis_out_tlast <= (rows_out == last_row);
                            half           <= 1'b1;
                        end else if (axis_out_tlast) begin
                            axis_out_tvalid <= 1'b0;
                            axis_out_tlast  <= 1'b0;
                            half            <= 1'b0;
                            state           <= DONE;
                        end else if (count > CW'(1)) begin
                            // Head is popped this edge; the following row starts without a bubble.
                            axis_out_tdata <= head_next[DATA_W-1:0];
                            axis_out_tlast <= 1'b0;
                            half           <= 1'b0;
                        end else begin
                            axis_out_tvalid <= 1'b0;
                            half            <= 1'b0;
                        end
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axis_result_tx.sv
// Bench for axis_result_tx: table of tile scenarios driven cycle by cycle against a
// row/beat-level model (accepted rows, buffered rows, expected beat list).
module tb_axis_result_tx;

    localparam int DATA_W     = 64;
    localparam int ROW_W      = 128;
    localparam int FIFO_DEPTH = 4;
    localparam int M_W        = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              i_start;
    logic [M_W-1:0]    i_cfg_m_dim;
    logic              i_row_valid;
    logic              o_row_ready;
    logic [ROW_W-1:0]  i_row_data;
    logic [DATA_W-1:0] axis_out_tdata;
    logic              axis_out_tvalid;
    logic              axis_out_tready;
    logic              axis_out_tlast;
    logic              o_busy;
    logic              o_done;

    axis_result_tx #(
        .DATA_W(DATA_W), .ROW_W(ROW_W), .FIFO_DEPTH(FIFO_DEPTH), .M_W(M_W)
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_cfg_m_dim(i_cfg_m_dim),
        .i_row_valid(i_row_valid), .o_row_ready(o_row_ready), .i_row_data(i_row_data),
        .axis_out_tdata(axis_out_tdata), .axis_out_tvalid(axis_out_tvalid),
        .axis_out_tready(axis_out_tready), .axis_out_tlast(axis_out_tlast),
        .o_busy(o_busy), .o_done(o_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [ROW_W-1:0] rows [64];

    typedef struct {
        int m;
        int offer;
        int rdy;        // 0: always ready, 1: 1-0-0 pattern, 2: random
        int vld;        // 0: always valid, 1: random, 2: every other cycle
        bit pat;        // 1: structured row pattern, 0: random payload
        int exp_beats;
        int exp_last;
        int exp_done;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_tile(input int m, input int offer, input int rdy, input int vld,
                            input bit pat, input int stop_beats,
                            output int beats, output int last_idx, output int done_cnt);
        int acc, popped, first_acc, first_hs, last_hs, budget;
        bit busy_exp, done_pend, seen_valid, prev_stall, finished, stopped, exp_ready;
        logic [63:0] prev_d, exp_d;
        logic prev_l;
        logic [7:0] r8;
        for (int i = 0; i < offer; i++) begin
            r8 = i[7:0];
            if (pat) rows[i] = {{8{r8 + 8'h80}}, {8{r8}}};
            else     rows[i] = {$urandom, $urandom, $urandom, $urandom};
        end
        beats = 0; last_idx = -1; done_cnt = 0;
        acc = 0; popped = 0; first_acc = -100; first_hs = 0; last_hs = 0;
        busy_exp = (m != 0); done_pend = (m == 0);
        seen_valid = 0; prev_stall = 0; finished = 0; stopped = 0;
        prev_d = '0; prev_l = 1'b0;
        budget = 100 + 20 * m;

        @(negedge clk);
        check("idle_valid", axis_out_tvalid, 1'b0);
        check("idle_done", o_done, 1'b0);
        i_cfg_m_dim = m[M_W-1:0];
        i_start = 1'b1;

        for (int cyc = 0; cyc < budget; cyc++) begin
            @(negedge clk);
            i_start = 1'b0;
            check("busy", o_busy, busy_exp);
            check("done", o_done, done_pend);
            exp_ready = busy_exp && ((acc - popped) < FIFO_DEPTH) && (acc < m);
            check("row_ready", o_row_ready, exp_ready);
            if (prev_stall) begin
                check("stall_valid", axis_out_tvalid, 1'b1);
                check("stall_data", axis_out_tdata, prev_d);
                check("stall_last", axis_out_tlast, prev_l);
            end
            if (axis_out_tvalid && !seen_valid) begin
                seen_valid = 1;
                check("row_to_beat_latency", cyc, first_acc + 2);
            end
            if (done_pend) begin
                if (o_done) done_cnt++;
                finished = 1;
                break;
            end

            axis_out_tready = (rdy == 0) ? 1'b1 :
                              (rdy == 1) ? ((cyc % 3) == 0) : 1'($urandom_range(0, 1));
            i_row_valid = (acc < offer) &&
                          ((vld == 0) || (vld == 1 && $urandom_range(0, 3) != 0) ||
                           (vld == 2 && (cyc % 2) == 0));
            i_row_data = i_row_valid ? rows[acc] : '0;

            if (i_row_valid && o_row_ready) begin
                if (acc == 0) first_acc = cyc;
                acc++;
            end
            if (axis_out_tvalid && axis_out_tready) begin
                if (beats >= 2 * m) begin
                    check("extra_beat", beats, 2 * m);
                end else begin
                    exp_d = (beats % 2 == 0) ? rows[beats / 2][63:0] : rows[beats / 2][127:64];
                    check("beat_data", axis_out_tdata, exp_d);
                    check("beat_last", axis_out_tlast, beats == 2 * m - 1);
                end
                if (axis_out_tlast) last_idx = beats;
                if (beats % 2 == 1) popped++;
                if (beats == 0) first_hs = cyc;
                last_hs = cyc;
                beats++;
                if (beats == 2 * m) begin
                    busy_exp = 0;
                    done_pend = 1;
                end
                if (stop_beats != 0 && beats == stop_beats) begin
                    stopped = 1;
                    break;
                end
            end
            prev_stall = axis_out_tvalid && !axis_out_tready;
            prev_d = axis_out_tdata;
            prev_l = axis_out_tlast;
        end

        if (!stopped) begin
            if (!finished) check("timeout", 1'b1, 1'b0);
            check("rows_accepted", acc, m);
            if (rdy == 0 && vld != 1 && m > 0) check("no_bubble", last_hs - first_hs, 2 * m - 1);
            i_row_valid = 1'b0;
            i_row_data = '0;
            axis_out_tready = 1'b0;
        end
    endtask

    int beats, last_idx, done_cnt;

    initial begin
        rst = 1'b1;
        i_start = 1'b0;
        i_cfg_m_dim = '0;
        i_row_valid = 1'b0;
        i_row_data = '0;
        axis_out_tready = 1'b0;

        vecs[0] = '{m: 32, offer: 32, rdy: 0, vld: 0, pat: 1, exp_beats: 64, exp_last: 63, exp_done: 1};
        vecs[1] = '{m: 32, offer: 32, rdy: 1, vld: 0, pat: 1, exp_beats: 64, exp_last: 63, exp_done: 1};
        vecs[2] = '{m: 3,  offer: 10, rdy: 0, vld: 0, pat: 1, exp_beats: 6,  exp_last: 5,  exp_done: 1};
        vecs[3] = '{m: 0,  offer: 2,  rdy: 0, vld: 0, pat: 0, exp_beats: 0,  exp_last: -1, exp_done: 1};
        vecs[4] = '{m: 7,  offer: 7,  rdy: 2, vld: 1, pat: 0, exp_beats: 14, exp_last: 13, exp_done: 1};
        vecs[5] = '{m: 13, offer: 15, rdy: 2, vld: 2, pat: 0, exp_beats: 26, exp_last: 25, exp_done: 1};
        vecs[6] = '{m: 1,  offer: 1,  rdy: 2, vld: 1, pat: 0, exp_beats: 2,  exp_last: 1,  exp_done: 1};
        vecs[7] = '{m: 5,  offer: 5,  rdy: 0, vld: 2, pat: 0, exp_beats: 10, exp_last: 9,  exp_done: 1};
        vecs[8] = '{m: 4,  offer: 4,  rdy: 0, vld: 0, pat: 1, exp_beats: 8,  exp_last: 7,  exp_done: 1};
        vecs[9] = '{m: 4,  offer: 4,  rdy: 2, vld: 0, pat: 0, exp_beats: 8,  exp_last: 7,  exp_done: 1};

        repeat (3) @(negedge clk);
        check("rst_tvalid", axis_out_tvalid, 1'b0);
        check("rst_tlast", axis_out_tlast, 1'b0);
        check("rst_tdata", axis_out_tdata, 64'h0);
        check("rst_row_ready", o_row_ready, 1'b0);
        check("rst_busy", o_busy, 1'b0);
        check("rst_done", o_done, 1'b0);
        rst = 1'b0;

        // Consecutive entries start the cycle after the previous o_done (back-to-back tiles).
        for (int v = 0; v < 10; v++) begin
            run_tile(vecs[v].m, vecs[v].offer, vecs[v].rdy, vecs[v].vld, vecs[v].pat, 0,
                     beats, last_idx, done_cnt);
            check("tile_beats", beats, vecs[v].exp_beats);
            check("tile_last_idx", last_idx, vecs[v].exp_last);
            check("tile_done_pulses", done_cnt, vecs[v].exp_done);
        end

        // Reset in the middle of a tile, then a fresh short tile.
        run_tile(8, 8, 0, 0, 1, 5, beats, last_idx, done_cnt);
        check("pre_rst_beats", beats, 5);
        @(negedge clk);
        rst = 1'b1;
        i_row_valid = 1'b0;
        @(negedge clk);
        check("midrst_tvalid", axis_out_tvalid, 1'b0);
        check("midrst_tlast", axis_out_tlast, 1'b0);
        check("midrst_tdata", axis_out_tdata, 64'h0);
        check("midrst_busy", o_busy, 1'b0);
        check("midrst_row_ready", o_row_ready, 1'b0);
        check("midrst_done", o_done, 1'b0);
        rst = 1'b0;
        axis_out_tready = 1'b0;
        run_tile(2, 2, 0, 0, 0, 0, beats, last_idx, done_cnt);
        check("post_rst_beats", beats, 4);
        check("post_rst_last_idx", last_idx, 3);
        check("post_rst_done", done_cnt, 1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
